sram_march_bist: RTL

- Built-in self-test initiator that drives one port of the shared dual-port SRAM and checks its read data.
- Runs a 4-element March sequence over a programmable word range using the SRAM's active-low enable, write and byte-enable convention.
- Sits beside the firmware loader on port 1 of the SRAM; firmware or the test sequencer starts it and reads back the pass/fail result.

---
 rtl/sram_march_bist.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_march_bist.sv
// March BIST initiator for one SRAM port: up W(P), up R(P)W(~P),
// down R(~P)W(P), up R(P), with a one-stage read-compare pipeline.
module sram_march_bist #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH-1:0]   last_addr,
  input  logic [DATA_WIDTH-1:0]   pattern,
  output logic                    busy,
  output logic                    done,
  output logic                    fail,
  output logic [CNT_WIDTH-1:0]    err_count,
  output logic [ADDR_WIDTH-1:0]   fail_addr,
  output logic [DATA_WIDTH-1:0]   fail_data,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_data_in,
  output logic                    mem_enable,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_byte_en,
  input  logic [DATA_WIDTH-1:0]   mem_data_out
);

  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic [3:0] {
    IDLE, M0_W, M1_R, M1_W, M2_R, M2_W, M3_R, DRAIN, FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] pat_q, pat_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  en_q, en_d;
  logic                  we_q, we_d;
  logic [BW-1:0]         be_q, be_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fail_q, fail_d;
  logic [CNT_WIDTH-1:0]  err_q, err_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic [DATA_WIDTH-1:0] fdata_q, fdata_d;
  logic                  chk_q, chk_d;
  logic [DATA_WIDTH-1:0] cexp_q, cexp_d;
  logic [ADDR_WIDTH-1:0] caddr_q, caddr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      last_q  <= '0;
      pat_q   <= '0;
      din_q   <= '0;
      en_q    <= 1'b1;
      we_q    <= 1'b1;
      be_q    <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
      chk_q   <= 1'b0;
      cexp_q  <= '0;
      caddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      last_q  <= last_d;
      pat_q   <= pat_d;
      din_q   <= din_d;
      en_q    <= en_d;
      we_q    <= we_d;
      be_q    <= be_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      chk_q   <= chk_d;
      cexp_q  <= cexp_d;
      caddr_q <= caddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    base_d  = base_q;
    last_d  = last_q;
    pat_d   = pat_q;
    busy_d  = busy_q;
    done_d  = done_q;
    fail_d  = fail_q;
    err_d   = err_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    chk_d   = 1'b0;
    cexp_d  = cexp_q;
    caddr_d = caddr_q;
    en_d    = 1'b1;
    we_d    = 1'b1;
    be_d    = '1;
    din_d   = '0;

    // data for the read presented last cycle arrives now
    if (chk_q && (mem_data_out != cexp_q)) begin
      if (err_q != '1) err_d = err_q + CNT_WIDTH'(1);
      if (!fail_q) begin
        fail_d  = 1'b1;
        faddr_d = caddr_q;
        fdata_d = mem_data_out;
      end
    end

    unique case (state_q)
      M1_R, M3_R: begin
        chk_d   = 1'b1;
        cexp_d  = pat_q;
        caddr_d = addr_q;
      end
      M2_R: begin
        chk_d   = 1'b1;
        cexp_d  = ~pat_q;
        caddr_d = addr_q;
      end
      default: ;
    endcase

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          last_d  = last_addr;
          pat_d   = pattern;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          err_d   = '0;
          faddr_d = '0;
          fdata_d = '0;
          if (last_addr < base_addr) begin
            state_d = FINISH;
            done_d  = 1'b1;
            fail_d  = 1'b1;
          end else begin
            state_d = M0_W;
            addr_d  = base_addr;
            busy_d  = 1'b1;
          end
        end
      end
      M0_W: begin
        if (addr_q == last_q) begin
          state_d = M1_R;
          addr_d  = base_q;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
        end
      end
      M1_R: state_d = M1_W;
      M1_W: begin
        if (addr_q == last_q) begin
          state_d = M2_R;
        end else begin
          state_d = M1_R;
          addr_d  = addr_q + ADDR_WIDTH'(1);
        end
      end
      M2_R: state_d = M2_W;
      M2_W: begin
        if (addr_q == base_q) begin
          state_d = M3_R;
        end else begin
          state_d = M2_R;
          addr_d  = addr_q - ADDR_WIDTH'(1);
        end
      end
      M3_R: begin
        if (addr_q == last_q) begin
          state_d = DRAIN;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        state_d = FINISH;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && busy_q) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      chk_d   = 1'b0;
    end

    // mem port is driven from the state being entered
    unique case (state_d)
      M0_W, M2_W: begin
        en_d  = 1'b0;
        we_d  = 1'b0;
        be_d  = '0;
        din_d = pat_d;
      end
      M1_W: begin
        en_d  = 1'b0;
        we_d  = 1'b0;
        be_d  = '0;
        din_d = ~pat_d;
      end
      M1_R, M2_R, M3_R: en_d = 1'b0;
      default: ;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign err_count   = err_q;
  assign fail_addr   = faddr_q;
  assign fail_data   = fdata_q;
  assign mem_address = addr_q;
  assign mem_data_in = din_q;
  assign mem_enable  = en_q;
  assign mem_write   = we_q;
  assign mem_byte_en = be_q;

endmodule
